// File: rtl/auth_requester_port_pkg.sv
// rtl/auth_requester_port_pkg.sv - shared codes, widths and state type for the auth requester port
package auth_requester_port_pkg;

  // Requester identities as decoded by the driver
  localparam logic [1:0] REQ_ID_PD    = 2'b01;
  localparam logic [1:0] REQ_ID_DEBUG = 2'b10;

  // Requester roles
  localparam logic [1:0] ROLE_RESPONDER = 2'b01;
  localparam logic [1:0] ROLE_INITIATOR = 2'b10;

  // Result codes reported on rsp_err
  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_GRANT_TO = 3'd1;
  localparam logic [2:0] ERR_MSG_TO   = 3'd2;
  localparam logic [2:0] ERR_BAD_VER  = 3'd3;
  localparam logic [2:0] ERR_FOREIGN  = 3'd4;
  localparam logic [2:0] ERR_BAD_REQ  = 3'd5;

  localparam logic [7:0] PROTO_VER_DEFAULT = 8'h01;

  // USB control-transfer framing ahead of the auth header
  localparam int USB_BMRT_W  = 8;
  localparam int USB_BREQ_W  = 8;
  localparam int USB_WLEN_W  = 16;
  localparam int USB_FRAME_W = USB_BMRT_W + USB_BREQ_W + USB_WLEN_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_MSG,
    ST_CAPTURE,
    ST_ACK,
    ST_DONE
  } state_e;

  // Request byte layout must match the driver's decode: {id, role, 0, usb, type}
  function automatic logic [7:0] req_code(input logic [1:0] id, input logic [1:0] role,
                                          input logic usb, input logic [1:0] rtype);
    return {id, role, 1'b0, usb, rtype};
  endfunction

endpackage

// File: rtl/auth_msg_unpack.sv
// rtl/auth_msg_unpack.sv - splits a USB-framed or plain auth message into its fields
module auth_msg_unpack
  import auth_requester_port_pkg::*;
#(
  parameter int         MSG_W     = 512,
  parameter int         HDR_W     = 32,
  parameter logic [7:0] PROTO_VER = PROTO_VER_DEFAULT
) (
  input  logic [MSG_W-1:0]       msg_i,
  input  logic                   usb_i,
  output logic [USB_BMRT_W-1:0]  bmrt_o,
  output logic [USB_BREQ_W-1:0]  breq_o,
  output logic [USB_WLEN_W-1:0]  wlen_o,
  output logic [HDR_W-1:0]       header_o,
  output logic [MSG_W-HDR_W-1:0] payload_o,
  output logic                   ver_ok_o
);

  localparam int PL_W     = MSG_W - HDR_W;
  localparam int USB_PL_W = PL_W - USB_FRAME_W;

  // Field extraction; USB fields read as zero in plain framing
  always_comb begin
    bmrt_o    = '0;
    breq_o    = '0;
    wlen_o    = '0;
    header_o  = '0;
    payload_o = '0;
    if (usb_i) begin
      bmrt_o    = msg_i[MSG_W-1 -: USB_BMRT_W];
      breq_o    = msg_i[MSG_W-USB_BMRT_W-1 -: USB_BREQ_W];
      wlen_o    = msg_i[MSG_W-USB_BMRT_W-USB_BREQ_W-1 -: USB_WLEN_W];
      header_o  = msg_i[MSG_W-USB_FRAME_W-1 -: HDR_W];
      payload_o = {{USB_FRAME_W{1'b0}}, msg_i[USB_PL_W-1:0]};
    end else begin
      header_o  = msg_i[MSG_W-1 -: HDR_W];
      payload_o = msg_i[PL_W-1:0];
    end
  end

  assign ver_ok_o = (header_o[HDR_W-1 -: 8] == PROTO_VER);

endmodule

// File: rtl/auth_requester_port.sv
// rtl/auth_requester_port.sv - requester-side endpoint of the authentication driver handshake
module auth_requester_port
  import auth_requester_port_pkg::*;
#(
  parameter int         MSG_W       = 512,
  parameter int         HDR_W       = 32,
  parameter logic [7:0] PROTO_VER   = PROTO_VER_DEFAULT,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [1:0] REQUESTER   = REQ_ID_PD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [1:0]             req_role,
  input  logic                   req_usb,
  input  logic [1:0]             req_type,
  output logic                   req_ready,
  output logic [7:0]             pending_auth_request,
  input  logic                   PD_in_ready,
  input  logic                   DEBUG_in_ready,
  input  logic                   auth_msg_ready,
  input  logic [MSG_W-1:0]       auth_msg_in,
  output logic                   Ack_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2:0]             rsp_err,
  output logic [7:0]             bmRequestType,
  output logic [7:0]             bRequest,
  output logic [15:0]            wLength,
  output logic [HDR_W-1:0]       header,
  output logic [MSG_W-HDR_W-1:0] payload
);

  localparam int            TW         = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_e                   state_q;
  logic [TW-1:0]            timer_q;
  logic [7:0]               pending_q;
  logic                     usb_q;
  logic                     ack_q;
  logic                     rsp_valid_q;
  logic [2:0]               err_q;
  logic [7:0]               bmrt_q;
  logic [7:0]               breq_q;
  logic [15:0]              wlen_q;
  logic [HDR_W-1:0]         header_q;
  logic [MSG_W-HDR_W-1:0]   payload_q;

  logic [7:0]               u_bmrt;
  logic [7:0]               u_breq;
  logic [15:0]              u_wlen;
  logic [HDR_W-1:0]         u_header;
  logic [MSG_W-HDR_W-1:0]   u_payload;
  logic                     u_ver_ok;

  logic own_grant;
  logic other_grant;
  logic timer_hit;
  logic role_ok;

  assign own_grant   = (REQUESTER == REQ_ID_DEBUG) ? DEBUG_in_ready : PD_in_ready;
  assign other_grant = (REQUESTER == REQ_ID_DEBUG) ? PD_in_ready : DEBUG_in_ready;
  assign timer_hit   = (timer_q >= TIMER_LAST);
  assign role_ok     = (req_role == ROLE_RESPONDER) || (req_role == ROLE_INITIATOR);

  auth_msg_unpack #(
    .MSG_W     (MSG_W),
    .HDR_W     (HDR_W),
    .PROTO_VER (PROTO_VER)
  ) u_unpack (
    .msg_i     (auth_msg_in),
    .usb_i     (usb_q),
    .bmrt_o    (u_bmrt),
    .breq_o    (u_breq),
    .wlen_o    (u_wlen),
    .header_o  (u_header),
    .payload_o (u_payload),
    .ver_ok_o  (u_ver_ok)
  );

  // Handshake FSM with wait-state timer and registered outputs; any state change clears the timer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pending_q   <= '0;
      usb_q       <= 1'b0;
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= ERR_OK;
      bmrt_q      <= '0;
      breq_q      <= '0;
      wlen_q      <= '0;
      header_q    <= '0;
      payload_q   <= '0;
    end else begin
      if (timer_q != '1) timer_q <= timer_q + TW'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            // Fresh request: drop any previous result so stale fields never leak
            usb_q     <= req_usb;
            err_q     <= ERR_OK;
            bmrt_q    <= '0;
            breq_q    <= '0;
            wlen_q    <= '0;
            header_q  <= '0;
            payload_q <= '0;
            timer_q   <= '0;
            if (role_ok) begin
              pending_q <= req_code(REQUESTER, req_role, req_usb, req_type);
              state_q   <= ST_REQUEST;
            end else begin
              err_q       <= ERR_BAD_REQ;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_REQUEST: begin
          if (own_grant) begin
            pending_q <= '0;
            timer_q   <= '0;
            state_q   <= ST_WAIT_MSG;
          end else if (other_grant || timer_hit) begin
            pending_q   <= '0;
            err_q       <= other_grant ? ERR_FOREIGN : ERR_GRANT_TO;
            rsp_valid_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_DONE;
          end
        end
        ST_WAIT_MSG: begin
          // A ready level with an all-zero bus is not a message
          if (auth_msg_ready && (auth_msg_in != '0)) begin
            timer_q <= '0;
            state_q <= ST_CAPTURE;
          end else if (timer_hit) begin
            err_q       <= ERR_MSG_TO;
            rsp_valid_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_DONE;
          end
        end
        ST_CAPTURE: begin
          bmrt_q    <= u_bmrt;
          breq_q    <= u_breq;
          wlen_q    <= u_wlen;
          header_q  <= u_header;
          payload_q <= u_payload;
          if (!u_ver_ok) err_q <= ERR_BAD_VER;
          ack_q     <= 1'b1;
          timer_q   <= '0;
          state_q   <= ST_ACK;
        end
        ST_ACK: begin
          if (!auth_msg_ready || timer_hit) begin
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign req_ready            = (state_q == ST_IDLE);
  assign pending_auth_request = pending_q;
  assign Ack_out              = ack_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_err              = err_q;
  assign bmRequestType        = bmrt_q;
  assign bRequest             = breq_q;
  assign wLength              = wlen_q;
  assign header               = header_q;
  assign payload              = payload_q;

endmodule

// File: tb/tb_auth_requester_port.sv
// tb/tb_auth_requester_port.sv - randomized self-checking bench for auth_requester_port
module tb_auth_requester_port;

  localparam int MSG_W = 512;
  localparam int HDR_W = 32;
  localparam int PL_W  = MSG_W - HDR_W;
  localparam int T     = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [1:0]       req_role;
  logic             req_usb;
  logic [1:0]       req_type;
  logic             req_ready;
  logic [7:0]       pending_auth_request;
  logic             PD_in_ready;
  logic             DEBUG_in_ready;
  logic             auth_msg_ready;
  logic [MSG_W-1:0] auth_msg_in;
  logic             Ack_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_err;
  logic [7:0]       bmRequestType;
  logic [7:0]       bRequest;
  logic [15:0]      wLength;
  logic [HDR_W-1:0] header;
  logic [PL_W-1:0]  payload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  auth_requester_port #(
    .MSG_W       (MSG_W),
    .HDR_W       (HDR_W),
    .PROTO_VER   (8'h01),
    .TIMEOUT_CYC (T),
    .REQUESTER   (2'b01)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_role             (req_role),
    .req_usb              (req_usb),
    .req_type             (req_type),
    .req_ready            (req_ready),
    .pending_auth_request (pending_auth_request),
    .PD_in_ready          (PD_in_ready),
    .DEBUG_in_ready       (DEBUG_in_ready),
    .auth_msg_ready       (auth_msg_ready),
    .auth_msg_in          (auth_msg_in),
    .Ack_out              (Ack_out),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_err              (rsp_err),
    .bmRequestType        (bmRequestType),
    .bRequest             (bRequest),
    .wLength              (wLength),
    .header               (header),
    .payload              (payload)
  );

  // One transaction scenario: g/m are grant/message delays in cycles (beyond T means never),
  // kind 0=own grant, 1=foreign grant, 2=both; d = cycles the driver holds ready after Ack
  typedef struct {
    logic [1:0]  role;
    logic        usb;
    logic [1:0]  rtype;
    int          g;
    int          kind;
    int          m;
    int          glitch;
    int          d;
    int          r;
    logic [7:0]  bmrt;
    logic [7:0]  breq;
    logic [15:0] wlen;
    logic [31:0] hdr;
  } txn_t;

  task automatic check_val(input string tag, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic [1:0] role, input logic usb, input int g, input int kind,
                              input int m, input int d, input int r, input logic [31:0] hdr,
                              input logic [7:0] bmrt, input logic [7:0] breq, input logic [15:0] wlen);
    txn_t t;
    t.role = role; t.usb = usb; t.rtype = 2'b00; t.g = g; t.kind = kind; t.m = m;
    t.glitch = 0; t.d = d; t.r = r; t.hdr = hdr; t.bmrt = bmrt; t.breq = breq; t.wlen = wlen;
    return t;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drives one transaction from IDLE back to IDLE; starts and ends on a falling edge
  task automatic run_txn(input txn_t t);
    logic [MSG_W-1:0] rnd;
    logic [MSG_W-1:0] msg;
    logic [PL_W-1:0]  exp_pl;
    logic [7:0]       exp_code;
    logic [2:0]       exp_err;
    logic             role_ok, granted, got_msg;
    int               exp_pend, exp_ack, pend_cnt, ack_cnt;

    for (int i = 0; i < MSG_W / 32; i++) rnd[i*32 +: 32] = $urandom();
    if (t.usb) begin
      msg    = {t.bmrt, t.breq, t.wlen, t.hdr, rnd[PL_W-33:0]};
      exp_pl = {32'h0, rnd[PL_W-33:0]};
    end else begin
      msg    = {t.hdr, rnd[PL_W-1:0]};
      exp_pl = rnd[PL_W-1:0];
    end

    role_ok  = (t.role == 2'b01) || (t.role == 2'b10);
    granted  = role_ok && (t.g <= T) && (t.kind != 1);
    got_msg  = granted && (t.m <= T);
    exp_code = {2'b01, t.role, 1'b0, t.usb, t.rtype};
    exp_pend = role_ok ? min2(t.g, T) : 0;
    exp_ack  = got_msg ? min2(t.d + 1, T) : 0;
    if (!role_ok)            exp_err = 3'd5;
    else if (t.g > T)        exp_err = 3'd1;
    else if (t.kind == 1)    exp_err = 3'd4;
    else if (t.m > T)        exp_err = 3'd2;
    else if (t.hdr[31:24] != 8'h01) exp_err = 3'd3;
    else                     exp_err = 3'd0;

    check_val("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_role = t.role; req_usb = t.usb; req_type = t.rtype;
    @(negedge clk);
    req_valid = 1'b0; req_role = 2'($urandom()); req_usb = 1'($urandom()); req_type = 2'($urandom());

    if (role_ok) begin
      pend_cnt = 0;
      for (int k = 0; k < T + 4; k++) begin
        if (pending_auth_request == 8'h00) break;
        if (k == 0) check_val("pend_code", pending_auth_request, exp_code);
        pend_cnt++;
        if (k == t.g - 1) begin
          PD_in_ready    = (t.kind != 1);
          DEBUG_in_ready = (t.kind != 0);
        end
        @(negedge clk);
        PD_in_ready = 1'b0; DEBUG_in_ready = 1'b0;
      end
      check_val("pend_cycles", pend_cnt, exp_pend);

      if (granted) begin
        for (int k = 0; k < min2(T, t.m - 1); k++) begin
          auth_msg_ready = (k < t.glitch);
          auth_msg_in    = '0;
          check_val("wait_no_ack", Ack_out, 0);
          check_val("wait_no_rsp", rsp_valid, 0);
          @(negedge clk);
        end
        if (t.m <= T) begin
          auth_msg_ready = 1'b1; auth_msg_in = msg;
          @(negedge clk);
          check_val("ack_lat1", Ack_out, 0);
          @(negedge clk);
          check_val("ack_lat2", Ack_out, 1);
          ack_cnt = 0;
          for (int k = 0; k < T + 4; k++) begin
            if (!Ack_out) break;
            ack_cnt++;
            if (k >= t.d) begin auth_msg_ready = 1'b0; auth_msg_in = '0; end
            @(negedge clk);
          end
          check_val("ack_cycles", ack_cnt, exp_ack);
        end
        auth_msg_ready = 1'b0; auth_msg_in = '0;
      end
    end

    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("pend_done", pending_auth_request, 0);
    check_val("ack_done", Ack_out, 0);
    check_val("bmrt", bmRequestType, (got_msg && t.usb) ? t.bmrt : 8'h00);
    check_val("breq", bRequest, (got_msg && t.usb) ? t.breq : 8'h00);
    check_val("wlen", wLength, (got_msg && t.usb) ? t.wlen : 16'h0000);
    check_val("header", header, got_msg ? t.hdr : 32'h0);
    check_val("payload", payload, got_msg ? exp_pl : '0);

    for (int i = 0; i < t.r; i++) begin
      req_valid = 1'b1; req_role = 2'b01;
      @(negedge clk);
      req_valid = 1'b0;
      check_val("rsp_hold", rsp_valid, 1);
      check_val("busy_req_ignored", pending_auth_request, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_released", rsp_valid, 0);
    check_val("back_idle", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    logic [31:0] w;

    reset = 1'b1; req_valid = 1'b0; req_role = 2'b00; req_usb = 1'b0; req_type = 2'b00;
    PD_in_ready = 1'b0; DEBUG_in_ready = 1'b0; auth_msg_ready = 1'b0; auth_msg_in = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pending", pending_auth_request, 0);
    check_val("rst_ack", Ack_out, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_err", rsp_err, 0);
    check_val("rst_header", header, 0);
    check_val("rst_req_ready", req_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // PD responder, USB framing, grant after 3 cycles
    run_txn(mk(2'b01, 1'b1, 3, 0, 2, 2, 0, 32'h01010000, 8'hC1, 8'h18, 16'h0040));
    // Initiator, plain framing
    run_txn(mk(2'b10, 1'b0, 1, 0, 1, 0, 2, 32'h01830000, 8'h00, 8'h00, 16'h0000));
    // No grant, no message, bad version, bad role
    run_txn(mk(2'b01, 1'b0, T + 3, 0, 1, 0, 0, 32'h01000000, 8'h00, 8'h00, 16'h0000));
    run_txn(mk(2'b01, 1'b1, 2, 0, T + 3, 0, 1, 32'h01000000, 8'h11, 8'h22, 16'h3333));
    run_txn(mk(2'b10, 1'b1, 1, 0, 2, 1, 0, 32'h02AABBCC, 8'h44, 8'h55, 16'h6666));
    run_txn(mk(2'b11, 1'b0, 1, 0, 1, 0, 1, 32'h01000000, 8'h00, 8'h00, 16'h0000));
    // Boundaries: grant/message on the last allowed cycle, Ack timeout, foreign and simultaneous grants
    run_txn(mk(2'b01, 1'b0, T, 0, T, T + 2, 0, 32'h01123456, 8'h00, 8'h00, 16'h0000));
    run_txn(mk(2'b01, 1'b0, 2, 1, 1, 0, 0, 32'h01000000, 8'h00, 8'h00, 16'h0000));
    run_txn(mk(2'b10, 1'b1, 4, 2, 3, 1, 0, 32'h01ABCDEF, 8'h0A, 8'h0B, 16'h0C0D));
    t = mk(2'b01, 1'b0, 1, 0, 5, 0, 0, 32'h01000001, 8'h00, 8'h00, 16'h0000);
    t.glitch = 3;
    run_txn(t);

    // Reset while in ACK with the message still offered
    req_valid = 1'b1; req_role = 2'b01; req_usb = 1'b0; req_type = 2'b01;
    @(negedge clk);
    req_valid = 1'b0; PD_in_ready = 1'b1;
    @(negedge clk);
    PD_in_ready = 1'b0; auth_msg_ready = 1'b1; auth_msg_in = {32'h01000000, 480'h5};
    repeat (2) @(negedge clk);
    check_val("pre_reset_ack", Ack_out, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_ack_drop", Ack_out, 0);
    check_val("reset_req_ready", req_ready, 1);
    check_val("reset_rsp_valid", rsp_valid, 0);
    check_val("reset_pending", pending_auth_request, 0);
    reset = 1'b0; auth_msg_ready = 1'b0; auth_msg_in = '0;
    @(negedge clk);
    run_txn(mk(2'b01, 1'b1, 2, 0, 2, 1, 0, 32'h01020304, 8'hC1, 8'h18, 16'h0040));

    // Randomized scenarios
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      t.role   = (sel < 2) ? 2'b01 : (sel < 4) ? 2'b10 : (sel == 4) ? 2'b11 : 2'b00;
      t.usb    = 1'($urandom());
      t.rtype  = 2'($urandom());
      t.g      = $urandom_range(1, T + 2);
      sel      = $urandom_range(0, 5);
      t.kind   = (sel == 4) ? 1 : (sel == 5) ? 2 : 0;
      t.m      = $urandom_range(1, T + 2);
      t.glitch = $urandom_range(0, 3);
      t.d      = $urandom_range(0, T + 1);
      t.r      = $urandom_range(0, 3);
      t.bmrt   = 8'($urandom());
      t.breq   = 8'($urandom());
      t.wlen   = 16'($urandom());
      w        = $urandom();
      t.hdr    = ($urandom_range(0, 3) != 0) ? {8'h01, w[23:0]}
                                             : {8'($urandom_range(2, 255)), w[23:0]};
      run_txn(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
